// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request/ready handshake,
// one-entry skid buffer for responses that land during a decode stall,
// and the IF/ID pipeline register. Redirect beats flush beats stall.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  fetch_stage_if.master     imem,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  logic [1:0] unused_tgt_lsb;
  assign unused_tgt_lsb = PCTargetE[1:0];

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pcf_q;
  assign InstrD         = instr_q;
  assign PCD            = pcd_q;
  assign PCPlus4D       = pcp4_q;
  assign ValidD         = valid_q;

  // Next-state and datapath: instr_q is forced to NOP whenever valid drops,
  // so InstrD never needs an output mux. PCF is not advanced on a stalled
  // accept, so in HOLD it still equals the skid PC (used for refetch).
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    pcp4_d       = pcp4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (PCSrcE) begin
      pcf_d   = {PCTargetE[XLEN-1:2], 2'b00};
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      state_d = FETCH;
    end else if (FlushD) begin
      if (state_q == HOLD) pcf_d = skid_pc_q;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem.imem_ready) begin
            if (!StallD) begin
              instr_d = imem.imem_rdata;
              pcd_d   = pcf_q;
              pcp4_d  = pcf_q + XLEN'(4);
              valid_d = 1'b1;
              pcf_d   = pcf_q + XLEN'(4);
            end else begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = pcf_q;
              state_d      = HOLD;
            end
          end else if (!StallD) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!StallD) begin
            instr_d = skid_instr_q;
            pcd_d   = skid_pc_q;
            pcp4_d  = skid_pc_q + XLEN'(4);
            valid_d = 1'b1;
            pcf_d   = pcf_q + XLEN'(4);
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and pipeline registers, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pcf_q        <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      pcp4_q       <= '0;
      valid_q      <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pcp4_q       <= pcp4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule
